// File: rtl/bit_guesser.sv
// bit_guesser: greedy bit-flip search driven by an external match-count judge.
// Optional feature macro EARLY_EXIT_EN: finish as soon as the score reaches N.
module bit_guesser #(
  parameter int N  = 32,
  parameter int SW = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [N-1:0]  seed_i,
  output logic [N-1:0]  guess_o,
  output logic          guess_valid_o,
  input  logic [SW-1:0] score_i,
  input  logic          score_valid_i,
  output logic          busy_o,
  output logic          found_o,
  output logic [SW-1:0] rounds_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [SW-1:0] NSC   = SW'(N);
  localparam logic [IW-1:0] ILAST = IW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    BASE,
    WAIT_BASE,
    FLIP,
    WAIT_FLIP,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  best_q, best_d;
  logic [N-1:0]  guess_q, guess_d;
  logic          gv_q, gv_d;
  logic [SW-1:0] bs_q, bs_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] rounds_q, rounds_d;

  logic          accept;
  logic [SW-1:0] sc;
  logic [SW-1:0] rounds_inc;
  logic [N-1:0]  flip;
  logic          better;
  logic [N-1:0]  kbest;
  logic [SW-1:0] kbs;

  // Score acceptance, clamping and candidate datapath
  always_comb begin
    accept     = gv_q & score_valid_i;
    sc         = (score_i > NSC) ? NSC : score_i;
    rounds_inc = (rounds_q == '1) ? rounds_q : rounds_q + 1'b1;
    flip       = best_q ^ (N'(1) << idx_q);
    better     = sc > bs_q;
    kbest      = better ? guess_q : best_q;
    kbs        = better ? sc : bs_q;
  end

  // Next-state and register-update logic
  always_comb begin
    logic done_now;
    state_d  = state_q;
    best_d   = best_q;
    guess_d  = guess_q;
    gv_d     = gv_q;
    bs_d     = bs_q;
    idx_d    = idx_q;
    rounds_d = rounds_q;
    done_now = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          best_d   = seed_i;
          rounds_d = '0;
          state_d  = BASE;
        end
      end
      BASE: begin
        guess_d = best_q;
        gv_d    = 1'b1;
        state_d = WAIT_BASE;
      end
      WAIT_BASE: begin
        if (accept) begin
          gv_d     = 1'b0;
          rounds_d = rounds_inc;
          bs_d     = sc;
          idx_d    = '0;
          state_d  = FLIP;
`ifdef EARLY_EXIT_EN
          if (sc == NSC) begin
            guess_d = best_q;
            state_d = DONE;
          end
`else
`endif
        end
      end
      FLIP: begin
        guess_d = flip;
        gv_d    = 1'b1;
        state_d = WAIT_FLIP;
      end
      WAIT_FLIP: begin
        if (accept) begin
          gv_d     = 1'b0;
          rounds_d = rounds_inc;
          best_d   = kbest;
          bs_d     = kbs;
          done_now = idx_q == ILAST;
`ifdef EARLY_EXIT_EN
          done_now = done_now | (kbs == NSC);
`else
`endif
          if (done_now) begin
            guess_d = kbest;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = FLIP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      best_q   <= '0;
      guess_q  <= '0;
      gv_q     <= 1'b0;
      bs_q     <= '0;
      idx_q    <= '0;
      rounds_q <= '0;
    end else begin
      state_q  <= state_d;
      best_q   <= best_d;
      guess_q  <= guess_d;
      gv_q     <= gv_d;
      bs_q     <= bs_d;
      idx_q    <= idx_d;
      rounds_q <= rounds_d;
    end
  end

  // Status outputs follow the state register
  always_comb begin
    guess_o       = guess_q;
    guess_valid_o = gv_q;
    rounds_o      = rounds_q;
    found_o       = state_q == DONE;
    busy_o        = (state_q != IDLE) && (state_q != DONE);
  end

endmodule

// File: tb/tb_bit_guesser.sv
// tb_bit_guesser: directed scoreboard bench for bit_guesser (N=8, SW=4).
// The judge answers popcount(~(guess^target)) one cycle after guess_valid.
module tb_bit_guesser;

  localparam int N  = 8;
  localparam int SW = 4;
`ifdef EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  seed;
  logic [N-1:0]  guess;
  logic          gv;
  logic [SW-1:0] score;
  logic          sv;
  logic          busy;
  logic          found;
  logic [SW-1:0] rounds;

  logic          judge_en = 1'b0;
  logic          judge_sv = 1'b0;
  logic [SW-1:0] judge_sc = '0;
  logic          man_sv   = 1'b0;
  logic [SW-1:0] man_sc   = '0;
  logic [N-1:0]  target   = '0;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string        tag;
    logic [N-1:0] g;
    logic [SW-1:0] r;
  } exp_t;
  exp_t sb[$];

  assign sv    = judge_sv | man_sv;
  assign score = judge_sv ? judge_sc : man_sc;

  always #5 clk = ~clk;

  bit_guesser #(.N(N), .SW(SW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .seed_i       (seed),
    .guess_o      (guess),
    .guess_valid_o(gv),
    .score_i      (score),
    .score_valid_i(sv),
    .busy_o       (busy),
    .found_o      (found),
    .rounds_o     (rounds)
  );

  always @(posedge clk) begin
    #1;
    if (judge_en && gv && !judge_sv) begin
      judge_sv = 1'b1;
      judge_sc = SW'($countones(~(guess ^ target)));
    end else begin
      judge_sv = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [N-1:0] s,
                                input logic [N-1:0] t,
                                output logic [N-1:0] g,
                                output logic [SW-1:0] r);
    int bs, sc, cnt;
    logic [N-1:0] b, c;
    b   = s;
    bs  = $countones(~(b ^ t));
    cnt = 1;
    if (!(EARLY && bs == N)) begin
      for (int i = 0; i < N; i++) begin
        c  = b ^ (N'(1) << i);
        sc = $countones(~(c ^ t));
        cnt++;
        if (sc > bs) begin
          b  = c;
          bs = sc;
        end
        if (EARLY && bs == N) break;
      end
    end
    g = b;
    r = SW'(cnt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push(input string tag, input logic [N-1:0] s,
                      input logic [N-1:0] t);
    exp_t e;
    e.tag = tag;
    model(s, t, e.g, e.r);
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [N-1:0] s);
    seed  = s;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_found();
    int n;
    exp_t e;
    n = 0;
    while (!found && n < 300) begin
      tick();
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, "_found"}, found, 1);
    chk({e.tag, "_guess"}, guess, e.g);
    chk({e.tag, "_rounds"}, rounds, e.r);
    chk({e.tag, "_busy"}, busy, 0);
    chk({e.tag, "_gv"}, gv, 0);
  endtask

  task automatic wait_gv();
    int n;
    n = 0;
    while (!gv && n < 20) begin
      tick();
      n++;
    end
    chk("wait_gv", gv, 1);
  endtask

  task automatic man_score(input logic [SW-1:0] s);
    man_sc = s;
    man_sv = 1'b1;
    tick();
    man_sv = 1'b0;
  endtask

  initial begin
    logic [N-1:0] g0;
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    seed  = '0;
    repeat (3) tick();
    chk("rst_guess", guess, 0);
    chk("rst_gv", gv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_found", found, 0);
    chk("rst_rounds", rounds, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    judge_en = 1'b1;
    target = 8'hA5;
    push("a5", 8'hA5, 8'hA5);
    do_start(8'hA5);
    chk("a5_busy", busy, 1);
    wait_found();

    target = 8'hFF;
    push("ff", 8'h00, 8'hFF);
    do_start(8'h00);
    wait_found();
    chk("ff_const", guess, 8'hFF);

    judge_en = 1'b0;
    target = 8'h0E;
    push("stall", 8'h0F, 8'h0E);
    do_start(8'h0F);
    wait_gv();
    chk("stall_base_guess", guess, 8'h0F);
    man_score(4'd7);
    chk("stall_r1", rounds, 1);
    wait_gv();
    g0 = guess;
    chk("stall_flip0", g0, 8'h0E);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_hold_g", guess, g0);
      chk("stall_hold_v", gv, 1);
      chk("stall_hold_r", rounds, 1);
    end
    man_score(4'd8);
    chk("stall_r2", rounds, 2);
    chk("stall_gv_drop", gv, 0);
    judge_en = 1'b1;
    wait_found();

    judge_en = 1'b0;
    target = 8'h34;
    do_start(8'h12);
    wait_gv();
    man_score(4'd15);
    judge_en = 1'b1;
    begin
      exp_t e;
      e.tag = "clamp";
      e.g   = 8'h12;
      e.r   = EARLY ? 4'd1 : 4'd9;
      sb.push_back(e);
    end
    wait_found();

    target = 8'hFF;
    push("busy_start", 8'h00, 8'hFF);
    do_start(8'h00);
    n = 0;
    while (rounds < 4 && n < 100) begin
      tick();
      n++;
    end
    seed  = 8'h5A;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bs_still_busy", busy, 1);
    chk("bs_rounds_kept", rounds >= 4, 1);
    wait_found();

    push("c3", 8'h3C, 8'hC3);
    target = 8'hFF;
    do_start(8'h00);
    n = 0;
    while (!(rounds == 2 && gv) && n < 100) begin
      tick();
      n++;
    end
    chk("rst_mid_reached", gv, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_guess", guess, 0);
    chk("mid_gv", gv, 0);
    chk("mid_busy", busy, 0);
    chk("mid_found", found, 0);
    chk("mid_rounds", rounds, 0);
    judge_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    man_sc = 4'd5;
    man_sv = 1'b1;
    repeat (3) tick();
    man_sv = 1'b0;
    chk("stale_rounds", rounds, 0);
    chk("stale_busy", busy, 0);
    chk("stale_gv", gv, 0);
    judge_en = 1'b1;
    target = 8'hC3;
    do_start(8'h3C);
    wait_found();
    chk("c3_const", guess, 8'hC3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
